// File: rtl/alu_op_arbiter_pkg.sv
// Shared definitions for the ALU op arbiter: FSM states, ALU ctl codes, sizing helper.
package alu_op_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   localparam int ALU_CTL_AND = 0;
   localparam int ALU_CTL_ADD = 1;
   localparam int ALU_CTL_SUB = 2;
   localparam int ALU_CTL_OR  = 3;
   localparam int ALU_CTL_XOR = 4;
   localparam int ALU_CTL_MAX = 4;

   // Latency counter must reach RESULT_LAT-1, and RESULT_LAT tops out at 7.
   localparam int LAT_W = 3;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_op_arbiter_if.sv
// Requester, ALU and response signals of the ALU op arbiter bundled as one bus.
interface alu_op_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int CTL_W   = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*CTL_W-1:0] req_op;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [CTL_W-1:0]         alu_ctl;
   logic [WIDTH-1:0]         alu_a;
   logic [WIDTH-1:0]         alu_b;
   logic [WIDTH-1:0]         alu_result;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [2:0]               rsp_id;
   logic [WIDTH-1:0]         rsp_data;
   logic                     rsp_err;
   logic                     busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
      output req_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
      input  req_ready, alu_ctl, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
   );

endinterface

// File: rtl/alu_op_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      int pos;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!any && ((req >> pos) & N'(1)) != '0) begin
            any   = 1'b1;
            grant = N'(1) << pos;
            idx   = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters: grant, execute, respond.
// Optional illegal-op check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_op_arbiter
   import alu_op_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 32,
   parameter int CTL_W      = 4,
   parameter int RESULT_LAT = 1
) (
   input logic           clk,
   input logic           rst_n,
   alu_op_arbiter_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RESULT_LAT - 1);

   arb_state_t       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] grant_idx;
   logic [NUM_REQ-1:0] grant_vec;
   logic             grant_any;
   logic [LAT_W-1:0] lat_cnt;
   logic [CTL_W-1:0] op_sel;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic             op_illegal;
   logic [CTL_W-1:0] alu_ctl_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [2:0]       rsp_id_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             busy_q;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant_vec),
      .idx   (grant_idx),
      .any   (grant_any)
   );

   assign op_sel = bus.req_op[grant_idx*CTL_W +: CTL_W];
   assign a_sel  = bus.req_a[grant_idx*WIDTH +: WIDTH];
   assign b_sel  = bus.req_b[grant_idx*WIDTH +: WIDTH];

`ifdef ALU_ARB_OPCHECK_EN
   assign op_illegal = (op_sel > CTL_W'(ALU_CTL_MAX));
`else
   assign op_illegal = 1'b0;
`endif

   // Gated by rst_n so the accept pulse is also silent while reset is held.
   assign bus.req_ready = (state == ST_IDLE && rst_n) ? grant_vec : '0;
   assign bus.alu_ctl   = alu_ctl_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         lat_cnt     <= '0;
         alu_ctl_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                  rsp_id_q <= 3'(grant_idx);
                  lat_cnt  <= '0;
                  busy_q   <= 1'b1;
                  // An illegal op never reaches the ALU, so its last inputs stay put.
                  if (op_illegal) begin
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_valid_q <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     alu_ctl_q <= op_sel;
                     alu_a_q   <= a_sel;
                     alu_b_q   <= b_sel;
                     rsp_err_q <= 1'b0;
                     state     <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (lat_cnt == LAT_END) begin
                  rsp_data_q  <= bus.alu_result;
                  lat_cnt     <= '0;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Self-checking bench for alu_op_arbiter: directed steps plus randomized traffic
// against a queue-free behavioural model; honours ALU_ARB_OPCHECK_EN when defined.
module tb_alu_op_arbiter;

   localparam int NR  = 4;
   localparam int W   = 32;
   localparam int CW  = 4;
   localparam int LAT = 3;

`ifdef ALU_ARB_OPCHECK_EN
   localparam bit OPCHECK = 1'b1;
`else
   localparam bit OPCHECK = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   alu_op_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .CTL_W(CW)) bus ();

   alu_op_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CTL_W(CW), .RESULT_LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: pending requests, round-robin pointer, last inputs shown to the ALU.
   bit          pend [NR];
   logic [CW-1:0] pOp [NR];
   logic [W-1:0]  pA  [NR];
   logic [W-1:0]  pB  [NR];
   int          mPtr;
   logic [CW-1:0] lastCtl;
   logic [W-1:0]  lastA;
   logic [W-1:0]  lastB;

   function automatic logic [W-1:0] aluRef(input logic [CW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Bench ALU: answer is only correct once inputs have been stable long enough.
   logic [CW+2*W-1:0] curIn;
   logic [CW+2*W-1:0] prevIn = '0;
   int                age = 0;
   int                ageEff;

   always_comb begin
      curIn  = {bus.alu_ctl, bus.alu_a, bus.alu_b};
      ageEff = (curIn !== prevIn) ? 0 : age + 1;
      bus.alu_result = (ageEff >= LAT - 1) ? aluRef(bus.alu_ctl, bus.alu_a, bus.alu_b)
                                           : ~aluRef(bus.alu_ctl, bus.alu_a, bus.alu_b);
   end

   always @(posedge clk) begin
      prevIn <= curIn;
      age    <= (curIn !== prevIn) ? 0 : ((age < 1000) ? age + 1 : age);
   end

   function automatic int expGrant();
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (mPtr + k) % NR;
         if (pend[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      logic [NR-1:0]    v;
      logic [NR*CW-1:0] o;
      logic [NR*W-1:0]  a;
      logic [NR*W-1:0]  b;
      for (int i = 0; i < NR; i++) begin
         v[i]          = pend[i];
         o[i*CW +: CW] = pOp[i];
         a[i*W +: W]   = pA[i];
         b[i*W +: W]   = pB[i];
      end
      bus.req_valid = v;
      bus.req_op    = o;
      bus.req_a     = a;
      bus.req_b     = b;
   endtask

   task automatic setReq(input int i, input logic [CW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      pend[i] = 1'b1;
      pOp[i]  = op;
      pA[i]   = a;
      pB[i]   = b;
   endtask

   task automatic randReq(input int i);
      setReq(i, CW'($urandom_range(0, 7)), $urandom, $urandom);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      checkOutput({tag, "_busy"},      64'(bus.busy),      64'd0);
      checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      checkOutput({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
      checkOutput({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
      checkOutput({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
      checkOutput({tag, "_alu_ctl"},   64'(bus.alu_ctl),   64'd0);
      checkOutput({tag, "_alu_a"},     64'(bus.alu_a),     64'd0);
      checkOutput({tag, "_alu_b"},     64'(bus.alu_b),     64'd0);
   endtask

   // One IDLE decision; if something is granted, follow it through EXEC and RESP.
   task automatic serveOne(input int stall, input bit refill);
      int            g;
      logic [CW-1:0] op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  expData;
      bit            illegal;
      applyStimulus();
      #1;
      g = expGrant();
      checkOutput("idle_req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      checkOutput("idle_busy", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      if (g < 0) return;
      op      = pOp[g];
      a       = pA[g];
      b       = pB[g];
      illegal = OPCHECK && (op > 4);
      pend[g] = 1'b0;
      mPtr    = (g + 1) % NR;
      if (refill) randReq(g);
      applyStimulus();
      if (!illegal) begin
         lastCtl = op;
         lastA   = a;
         lastB   = b;
      end
      expData = illegal ? '0 : aluRef(op, a, b);
      for (int c = 0; c < (illegal ? 0 : LAT); c++) begin
         checkOutput("exec_busy",      64'(bus.busy),      64'd1);
         checkOutput("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         checkOutput("exec_req_ready", 64'(bus.req_ready), 64'd0);
         checkOutput("exec_alu_ctl",   64'(bus.alu_ctl),   64'(lastCtl));
         checkOutput("exec_alu_a",     64'(bus.alu_a),     64'(lastA));
         checkOutput("exec_alu_b",     64'(bus.alu_b),     64'(lastB));
         @(posedge clk);
         #1;
      end
      for (int s = 0; s <= stall; s++) begin
         bus.rsp_ready = (s == stall);
         checkOutput("resp_valid",     64'(bus.rsp_valid), 64'd1);
         checkOutput("resp_id",        64'(bus.rsp_id),    64'(g));
         checkOutput("resp_data",      64'(bus.rsp_data),  64'(expData));
         checkOutput("resp_err",       64'(bus.rsp_err),   64'(illegal));
         checkOutput("resp_req_ready", 64'(bus.req_ready), 64'd0);
         checkOutput("resp_busy",      64'(bus.busy),      64'd1);
         checkOutput("resp_alu_ctl",   64'(bus.alu_ctl),   64'(lastCtl));
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b0;
      checkOutput("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("post_busy",      64'(bus.busy),      64'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mPtr  = 0;
      lastCtl = '0;
      lastA   = '0;
      lastB   = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0;
         pOp[i]  = '0;
         pA[i]   = '0;
         pB[i]   = '0;
      end
      rst_n         = 1'b0;
      bus.rsp_ready = 1'b0;
      applyStimulus();

      $display("[TB] reset and idle");
      #12;
      checkResetOutputs("reset");
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checkOutput("idle_no_ready", 64'(bus.req_ready), 64'd0);
         checkOutput("idle_not_busy", 64'(bus.busy), 64'd0);
      end

      $display("[TB] fairness with all requesters held");
      for (int i = 0; i < NR; i++) randReq(i);
      for (int n = 0; n < 6; n++) serveOne(0, 1'b1);

      $display("[TB] single op from requester 2");
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      serveOne(0, 1'b0);
      setReq(2, 4'd1, 32'd5, 32'd3);
      serveOne(0, 1'b0);

      $display("[TB] response backpressure");
      setReq(1, 4'd2, 32'd100, 32'd58);
      serveOne(5, 1'b0);

      $display("[TB] reset during EXEC");
      setReq(2, 4'd3, $urandom, $urandom);
      applyStimulus();
      #1;
      checkOutput("rst_grant", 64'(bus.req_ready), 64'd1 << expGrant());
      @(posedge clk);
      #1;
      pend[2] = 1'b0;
      applyStimulus();
      checkOutput("rst_in_exec", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midexec");
      mPtr    = 0;
      lastCtl = '0;
      lastA   = '0;
      lastB   = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_held_no_rsp", 64'(bus.rsp_valid), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_dropped_rsp", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_dropped_busy", 64'(bus.busy), 64'd0);
      randReq(1);
      randReq(3);
      serveOne(0, 1'b0);
      serveOne(1, 1'b0);

`ifdef ALU_ARB_OPCHECK_EN
      $display("[TB] illegal op");
      setReq(0, 4'd7, 32'h1234_5678, 32'h9abc_def0);
      serveOne(0, 1'b0);
      setReq(0, 4'd4, 32'hffff_0000, 32'h0f0f_0f0f);
      serveOne(0, 1'b0);
`endif

      $display("[TB] randomized traffic");
      for (int it = 0; it < 60; it++) begin
         for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) randReq(i);
            else if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
         end
         serveOne(int'($urandom_range(0, 3)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
